aurora_tx_scheduler: RTL and testbench



---
 rtl/aurora_tx_pkg.sv | 41 ++++
 rtl/aurora_tx_scheduler_rr_arb2.sv | 46 ++++
 rtl/aurora_tx_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_aurora_tx_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_tx_pkg.sv
// Shared types and constants for the Aurora TX scheduler.
//
// Holds the scheduler state encoding, the frame header layout and a helper
// that assembles a header word from its fields.
//
// Optional feature macro: AURORA_TX_SCHED_CHKSUM_EN adds the TRL state.
package aurora_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3
`ifdef AURORA_TX_SCHED_CHKSUM_EN
    ,
    ST_TRL  = 3'd4
`endif
  } tx_state_e;

  localparam logic [3:0] HDR_MAGIC     = 4'hA;
  localparam int         HDR_MAGIC_LSB = 28;
  localparam int         HDR_CHK_BIT   = 27;
  localparam int         HDR_ID_LSB    = 24;
  localparam int         HDR_LEN_LSB   = 0;
  localparam int         HDR_LEN_W     = 16;
  localparam int         CH_ID_W       = 1;

  // Header: magic | checksum-present | reserved | channel id | reserved | len
  function automatic logic [31:0] make_header(input logic                 chk,
                                              input logic [CH_ID_W-1:0]   id,
                                              input logic [HDR_LEN_W-1:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 4]       = HDR_MAGIC;
    h[HDR_CHK_BIT]              = chk;
    h[HDR_ID_LSB +: CH_ID_W]    = id;
    h[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return h;
  endfunction

endpackage

// File: rtl/aurora_tx_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   req[1:0]        per-channel request
//   advance         pulse on frame completion; hands priority to the
//                   channel that was not just served
//   gnt[1:0]        one-hot grant (combinational)
//   gnt_id          index of the granted channel
//
// Priority sits with ch0 out of reset. The pointer moves only on advance,
// so an aborted frame leaves the same channel first in line.
module rr_arb2
  import aurora_tx_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         req,
  input  logic               advance,
  output logic [1:0]         gnt,
  output logic [CH_ID_W-1:0] gnt_id
);

  logic prio_q;

  always_comb begin
    gnt_id = '0;
    gnt    = 2'b00;
    if (req[prio_q]) begin
      gnt_id = prio_q;
      gnt    = prio_q ? 2'b10 : 2'b01;
    end else if (req[~prio_q]) begin
      gnt_id = ~prio_q;
      gnt    = prio_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_q <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      prio_q <= ~gnt_id[0];
    end
  end

endmodule

// File: rtl/aurora_tx_scheduler.sv
// aurora_tx_scheduler: shares one Aurora LocalLink TX port between two
// first-word-fall-through prefetch FIFOs. Channels holding data are served
// round-robin; each grant is sent as one frame: a header word followed by up
// to MAX_BURST payload words popped straight from the granted FIFO.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   chN_fifo_empty_i/cnt_i/dat_i   FIFO empty flag, occupancy, head word
//   chN_fifo_rd_o                  pop strobe (combinational)
//   channel_up_i                   Aurora link up; low aborts the frame
//   tx_d_o, tx_*_n_o               LocalLink TX data and active-low controls
//   tx_dst_rdy_n_i                 LocalLink destination ready (active-low)
//   busy_o                         high whenever the FSM is not IDLE
//
// Build option: AURORA_TX_SCHED_CHKSUM_EN appends a trailer word carrying the
// modulo-2^32 sum of the payload and sets header bit 27.
//
// State | meaning
// IDLE  | waiting for link up and a non-empty FIFO
// ARB   | pick a channel, latch frame length from its occupancy
// HDR   | present header with SOF until accepted
// DATA  | stream payload from the granted FIFO, count down remaining words
// TRL   | present checksum with EOF until accepted (checksum build only)
module aurora_tx_scheduler
  import aurora_tx_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 18
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ch0_fifo_empty_i,
  input  logic [CNT_W-1:0]  ch0_fifo_cnt_i,
  input  logic [DATA_W-1:0] ch0_fifo_dat_i,
  output logic              ch0_fifo_rd_o,
  input  logic              ch1_fifo_empty_i,
  input  logic [CNT_W-1:0]  ch1_fifo_cnt_i,
  input  logic [DATA_W-1:0] ch1_fifo_dat_i,
  output logic              ch1_fifo_rd_o,
  input  logic              channel_up_i,
  output logic [DATA_W-1:0] tx_d_o,
  output logic              tx_sof_n_o,
  output logic              tx_eof_n_o,
  output logic              tx_src_rdy_n_o,
  input  logic              tx_dst_rdy_n_i,
  output logic              busy_o
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("aurora_tx_scheduler: DATA_W must be 32");
  end
  if ((MAX_BURST < 1) || (MAX_BURST > 65535)) begin : g_bad_max_burst
    $error("aurora_tx_scheduler: MAX_BURST must be 1..65535");
  end

`ifdef AURORA_TX_SCHED_CHKSUM_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  tx_state_e          state_q, state_d;
  logic [CH_ID_W-1:0] gnt_id_q;
  logic [15:0]        len_q;
  logic [15:0]        rem_q;
`ifdef AURORA_TX_SCHED_CHKSUM_EN
  logic [DATA_W-1:0]  sum_q;
`endif

  logic [1:0]         arb_req;
  logic [1:0]         arb_gnt;
  logic [CH_ID_W-1:0] arb_gnt_id;
  logic               arb_adv;

  logic [CNT_W-1:0]   arb_cnt;
  logic [31:0]        arb_cnt_ext;
  logic [15:0]        len_arb;

  logic               sel_empty;
  logic [DATA_W-1:0]  sel_dat;
  logic               pop;
  logic               last_pop;

  // Outside ARB the arbiter only sees the channel being served, so the
  // advance pulse at frame end credits that channel and not whatever happens
  // to be requesting at the time.
  assign arb_req = (state_q == ST_ARB) ? {~ch1_fifo_empty_i, ~ch0_fifo_empty_i}
                                       : (gnt_id_q[0] ? 2'b10 : 2'b01);

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req     (arb_req),
    .advance (arb_adv),
    .gnt     (arb_gnt),
    .gnt_id  (arb_gnt_id)
  );

  assign arb_cnt = arb_gnt_id[0] ? ch1_fifo_cnt_i : ch0_fifo_cnt_i;

  // A non-empty FIFO reporting zero occupancy still gets a one-word frame.
  always_comb begin
    arb_cnt_ext = 32'(arb_cnt);
    if (arb_cnt_ext == 32'd0) begin
      len_arb = 16'd1;
    end else if (arb_cnt_ext > 32'(MAX_BURST)) begin
      len_arb = 16'(MAX_BURST);
    end else begin
      len_arb = arb_cnt_ext[15:0];
    end
  end

  assign sel_empty = gnt_id_q[0] ? ch1_fifo_empty_i : ch0_fifo_empty_i;
  assign sel_dat   = gnt_id_q[0] ? ch1_fifo_dat_i   : ch0_fifo_dat_i;
  assign pop       = (state_q == ST_DATA) & ~sel_empty & ~tx_dst_rdy_n_i & channel_up_i;
  assign last_pop  = pop && (rem_q == 16'd1);
  assign busy_o    = (state_q != ST_IDLE);

  always_comb begin
    state_d        = state_q;
    tx_d_o         = '0;
    tx_sof_n_o     = 1'b1;
    tx_eof_n_o     = 1'b1;
    tx_src_rdy_n_o = 1'b1;
    ch0_fifo_rd_o  = 1'b0;
    ch1_fifo_rd_o  = 1'b0;
    arb_adv        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (channel_up_i && (~ch0_fifo_empty_i || ~ch1_fifo_empty_i)) begin
          state_d = ST_ARB;
        end
      end

      ST_ARB: begin
        if (!channel_up_i || (arb_gnt == 2'b00)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_HDR: begin
        tx_d_o         = make_header(CHK_EN, gnt_id_q, len_q);
        tx_sof_n_o     = 1'b0;
        tx_src_rdy_n_o = 1'b0;
        if (!channel_up_i) begin
          state_d = ST_IDLE;
        end else if (!tx_dst_rdy_n_i) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        tx_d_o         = sel_dat;
        tx_src_rdy_n_o = sel_empty;
`ifndef AURORA_TX_SCHED_CHKSUM_EN
        tx_eof_n_o     = (rem_q != 16'd1);
`endif
        ch0_fifo_rd_o  = pop & ~gnt_id_q[0];
        ch1_fifo_rd_o  = pop &  gnt_id_q[0];
        if (!channel_up_i) begin
          state_d = ST_IDLE;
        end else if (last_pop) begin
`ifdef AURORA_TX_SCHED_CHKSUM_EN
          state_d = ST_TRL;
`else
          state_d = ST_IDLE;
          arb_adv = 1'b1;
`endif
        end
      end

`ifdef AURORA_TX_SCHED_CHKSUM_EN
      ST_TRL: begin
        tx_d_o         = sum_q;
        tx_eof_n_o     = 1'b0;
        tx_src_rdy_n_o = 1'b0;
        if (!channel_up_i) begin
          state_d = ST_IDLE;
        end else if (!tx_dst_rdy_n_i) begin
          state_d = ST_IDLE;
          arb_adv = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= '0;
      len_q    <= '0;
      rem_q    <= '0;
`ifdef AURORA_TX_SCHED_CHKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARB) begin
        gnt_id_q <= arb_gnt_id;
        len_q    <= len_arb;
        rem_q    <= len_arb;
`ifdef AURORA_TX_SCHED_CHKSUM_EN
        sum_q    <= '0;
`endif
      end else if (pop) begin
        rem_q <= rem_q - 16'd1;
`ifdef AURORA_TX_SCHED_CHKSUM_EN
        sum_q <= sum_q + sel_dat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// Testbench for aurora_tx_scheduler: queue-based FIFO models feed the DUT,
// a frame-level monitor checks every LocalLink transfer against the words
// pushed per channel, and directed scenarios check exact headers and timing.
module tb_aurora_tx_scheduler;

  localparam int MAXB  = 64;
  localparam int CNT_W = 18;
`ifdef AURORA_TX_SCHED_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i;
  logic             ch0_empty, ch1_empty;
  logic [CNT_W-1:0] ch0_cnt, ch1_cnt;
  logic [31:0]      ch0_dat, ch1_dat;
  logic             ch0_rd, ch1_rd;
  logic             channel_up;
  logic [31:0]      tx_d;
  logic             tx_sof_n, tx_eof_n, tx_src_rdy_n;
  logic             dst_want;
  wire              tx_dst_rdy_n = dst_want | ~channel_up;
  logic             busy;

  aurora_tx_scheduler #(.MAX_BURST(MAXB), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .ch0_fifo_empty_i (ch0_empty),
    .ch0_fifo_cnt_i   (ch0_cnt),
    .ch0_fifo_dat_i   (ch0_dat),
    .ch0_fifo_rd_o    (ch0_rd),
    .ch1_fifo_empty_i (ch1_empty),
    .ch1_fifo_cnt_i   (ch1_cnt),
    .ch1_fifo_dat_i   (ch1_dat),
    .ch1_fifo_rd_o    (ch1_rd),
    .channel_up_i     (channel_up),
    .tx_d_o           (tx_d),
    .tx_sof_n_o       (tx_sof_n),
    .tx_eof_n_o       (tx_eof_n),
    .tx_src_rdy_n_o   (tx_src_rdy_n),
    .tx_dst_rdy_n_i   (tx_dst_rdy_n),
    .busy_o           (busy)
  );

  logic [31:0] fq0[$], fq1[$];
  logic [31:0] ref0[$], ref1[$];
  int checks = 0, errors = 0, cyc = 0;

  bit          in_frame, hold_valid, bp_mode, cnt0_zero;
  int          cur_id, f_len, f_got, frames_done, last_eof_cyc, last_pay_cyc;
  logic [31:0] f_sum, hold_word, last_pay_word, last_trl_word;
  logic [31:0] hdr_word[$];
  int          hdr_cyc[$], eof_cyc[$];
  int          pops0, pops1;
  logic        rd0_s, rd1_s;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_hdr(input int id, input int len);
    return {4'hA, CHK, 2'b00, id[0], 8'h00, len[15:0]};
  endfunction

  function automatic logic [31:0] hdr_at(input int i);
    if (i < hdr_word.size()) return hdr_word[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic drive_fifos();
    ch0_empty = (fq0.size() == 0);
    ch1_empty = (fq1.size() == 0);
    ch0_cnt   = cnt0_zero ? '0 : CNT_W'(fq0.size());
    ch1_cnt   = CNT_W'(fq1.size());
    ch0_dat   = (fq0.size() != 0) ? fq0[0] : 32'hDEADBEEF;
    ch1_dat   = (fq1.size() != 0) ? fq1[0] : 32'hDEADBEEF;
  endtask

  task automatic push(input int ch, input logic [31:0] w);
    if (ch == 0) begin fq0.push_back(w); ref0.push_back(w); end
    else begin fq1.push_back(w); ref1.push_back(w); end
    drive_fifos();
  endtask

  task automatic end_frame();
    in_frame = 0;
    frames_done++;
    last_eof_cyc = cyc;
    eof_cyc.push_back(cyc);
  endtask

  // Frame-level reference: every accepted word is checked against the
  // per-channel stream of pushed words.
  task automatic monitor();
    logic        xfer, pay;
    logic [15:0] len;
    logic [31:0] w;
    int          avail;
    rd0_s = ch0_rd;
    rd1_s = ch1_rd;
    if (reset_i) begin in_frame = 0; hold_valid = 0; return; end
    xfer = !tx_src_rdy_n && !tx_dst_rdy_n;
    pay  = xfer && in_frame && (f_got < f_len);
    check_eq("rd0", {31'd0, rd0_s}, {31'd0, pay && (cur_id == 0)});
    check_eq("rd1", {31'd0, rd1_s}, {31'd0, pay && (cur_id == 1)});
    pops0 += int'(rd0_s);
    pops1 += int'(rd1_s);
    if (!channel_up) begin in_frame = 0; hold_valid = 0; return; end
    if (hold_valid && !tx_src_rdy_n) check_eq("hold", tx_d, hold_word);
    hold_valid = !tx_src_rdy_n && tx_dst_rdy_n;
    hold_word  = tx_d;
    if (!xfer) return;
    if (!in_frame) begin
      check_eq("hdr_sof", {31'd0, tx_sof_n}, 0);
      check_eq("hdr_eof", {31'd0, tx_eof_n}, 1);
      check_eq("hdr_magic", {28'd0, tx_d[31:28]}, 32'hA);
      check_eq("hdr_chkbit", {31'd0, tx_d[27]}, {31'd0, CHK});
      check_eq("hdr_rsvd", {22'd0, tx_d[26:25], tx_d[23:16]}, 0);
      cur_id = int'(tx_d[24]);
      len    = tx_d[15:0];
      avail  = (cur_id == 1) ? ref1.size() : ref0.size();
      check_eq("hdr_len_range", {31'd0, (len >= 1) && (int'(len) <= MAXB) && (int'(len) <= avail)}, 1);
      check_eq("frame_gap", {31'd0, (cyc - last_eof_cyc) >= 3}, 1);
      in_frame = 1; f_len = int'(len); f_got = 0; f_sum = 0;
      hdr_word.push_back(tx_d);
      hdr_cyc.push_back(cyc);
    end else if (f_got < f_len) begin
      if (cur_id == 0 && ref0.size() > 0) w = ref0.pop_front();
      else if (cur_id == 1 && ref1.size() > 0) w = ref1.pop_front();
      else w = 32'hxxxxxxxx;
      check_eq("payload", tx_d, w);
      check_eq("pay_sof", {31'd0, tx_sof_n}, 1);
      check_eq("pay_eof", {31'd0, tx_eof_n}, {31'd0, !(!CHK && (f_got == f_len - 1))});
      f_sum += tx_d;
      f_got++;
      last_pay_cyc  = cyc;
      last_pay_word = tx_d;
      if (f_got == f_len && !CHK) end_frame();
    end else begin
      check_eq("trailer", tx_d, f_sum);
      check_eq("trl_eof", {31'd0, tx_eof_n}, 0);
      check_eq("trl_sof", {31'd0, tx_sof_n}, 1);
      last_trl_word = tx_d;
      end_frame();
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (rd0_s && fq0.size() > 0) void'(fq0.pop_front());
    if (rd1_s && fq1.size() > 0) void'(fq1.pop_front());
    drive_fifos();
    if (bp_mode) dst_want = in_frame ? ~dst_want : 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int target, k;
    target = frames_done + n;
    k = 0;
    while (frames_done < target && k < budget) begin step(); k++; end
    check_eq({tag, "_frames"}, frames_done, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_src"}, {31'd0, tx_src_rdy_n}, 1);
    check_eq({tag, "_sof"}, {31'd0, tx_sof_n}, 1);
    check_eq({tag, "_eof"}, {31'd0, tx_eof_n}, 1);
    check_eq({tag, "_d"}, tx_d, 0);
    check_eq({tag, "_rd"}, {30'd0, ch1_rd, ch0_rd}, 0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    fq0.delete(); fq1.delete(); ref0.delete(); ref1.delete();
    drive_fifos();
    step();
    check_idle_outputs("reset");
    step();
    reset_i = 1'b0;
  endtask

  initial begin : main
    int b, c, p0, p1, n, down;
    reset_i = 1'b1; channel_up = 1'b1; dst_want = 1'b0;
    bp_mode = 0; cnt0_zero = 0; in_frame = 0; hold_valid = 0;
    frames_done = 0; last_eof_cyc = -1000; last_pay_cyc = 0;
    pops0 = 0; pops1 = 0;
    drive_fifos();
    do_reset();
    step();
    check_eq("idle_busy", {31'd0, busy}, 0);

    // single channel, 3 words
    b = hdr_word.size(); p0 = pops0; c = cyc;
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
    wait_frames("single", 1, 50);
    check_eq("single_hdr", hdr_at(b), exp_hdr(0, 3));
    check_eq("single_latency", hdr_cyc[b] - c, 2);
    check_eq("single_pops", pops0 - p0, 3);
    check_eq("single_last", last_pay_word, 32'h33);
    check_eq("single_lastcyc", last_pay_cyc - c, 5);

    // burst cap: 100 words split 64 + 36
    b = hdr_word.size(); n = eof_cyc.size();
    for (int i = 0; i < 100; i++) push(1, 32'h1000 + i);
    wait_frames("burst", 2, 600);
    check_eq("burst_hdr0", hdr_at(b), exp_hdr(1, 64));
    check_eq("burst_hdr1", hdr_at(b + 1), exp_hdr(1, 36));
    if (hdr_cyc.size() > b + 1) check_eq("burst_gap", hdr_cyc[b + 1] - eof_cyc[n], 3);
    else check_eq("burst_gap_present", hdr_cyc.size(), b + 2);

    // round robin, twice
    for (int r = 0; r < 2; r++) begin
      b = hdr_word.size();
      for (int i = 0; i < 5; i++) begin push(0, $urandom); push(1, $urandom); end
      wait_frames("rr", 2, 100);
      check_eq("rr_first", hdr_at(b), exp_hdr(0, 5));
      check_eq("rr_second", hdr_at(b + 1), exp_hdr(1, 5));
    end

    // backpressure: dst_rdy alternates during the frame
    b = hdr_word.size(); p0 = pops0;
    bp_mode = 1;
    for (int i = 0; i < 4; i++) push(0, 32'hB0 + i);
    wait_frames("bp", 1, 60);
    bp_mode = 0; dst_want = 1'b0;
    check_eq("bp_hdr", hdr_at(b), exp_hdr(0, 4));
    if (hdr_cyc.size() > b) check_eq("bp_data_cycles", last_pay_cyc - hdr_cyc[b], 8);
    check_eq("bp_pops", pops0 - p0, 4);

    // link drop after 2 of 10 words; ch1 must be retried before ch0
    b = hdr_word.size(); p1 = pops1;
    for (int i = 0; i < 10; i++) push(1, 32'hC0 + i);
    n = 0;
    while (!(in_frame && f_got == 2) && n < 60) begin step(); n++; end
    check_eq("drop_reached", {31'd0, in_frame && f_got == 2}, 1);
    channel_up = 1'b0;
    step();
    check_idle_outputs("drop");
    check_eq("drop_pops", pops1 - p1, 2);
    check_eq("drop_left", fq1.size(), 8);
    for (int i = 0; i < 3; i++) push(0, 32'hD0 + i);
    repeat (3) step();
    check_eq("down_busy", {31'd0, busy}, 0);
    check_eq("down_pops", pops1 - p1, 2);
    channel_up = 1'b1;
    wait_frames("relink", 2, 100);
    check_eq("drop_hdr", hdr_at(b), exp_hdr(1, 10));
    check_eq("retry_hdr", hdr_at(b + 1), exp_hdr(1, 8));
    check_eq("next_hdr", hdr_at(b + 2), exp_hdr(0, 3));

    // occupancy reads 0 while not empty: one-word frames
    b = hdr_word.size();
    cnt0_zero = 1;
    push(0, 32'hE0); push(0, 32'hE1);
    wait_frames("zcnt", 2, 60);
    cnt0_zero = 0; drive_fifos();
    check_eq("zcnt_hdr0", hdr_at(b), exp_hdr(0, 1));
    check_eq("zcnt_hdr1", hdr_at(b + 1), exp_hdr(0, 1));

`ifdef AURORA_TX_SCHED_CHKSUM_EN
    b = hdr_word.size();
    push(0, 32'hFFFFFFFF); push(0, 32'h00000002);
    wait_frames("chksum", 1, 40);
    check_eq("chksum_hdr", hdr_at(b), 32'hA8000002);
    check_eq("chksum_trl", last_trl_word, 32'h00000001);
`endif

    // reset mid-frame, then pointer must be back at ch0
    for (int i = 0; i < 20; i++) push(0, $urandom);
    n = 0;
    while (!in_frame && n < 20) begin step(); n++; end
    repeat (3) step();
    do_reset();
    b = hdr_word.size();
    for (int i = 0; i < 3; i++) begin push(0, $urandom); push(1, $urandom); end
    wait_frames("postrst", 2, 60);
    check_eq("postrst_first", hdr_at(b), exp_hdr(0, 3));
    check_eq("postrst_second", hdr_at(b + 1), exp_hdr(1, 3));

    // randomized traffic, backpressure and link drops
    down = 0;
    for (int i = 0; i < 4000; i++) begin
      if (fq0.size() < 150 && $urandom_range(0, 3) == 0) push(0, $urandom);
      if (fq1.size() < 150 && $urandom_range(0, 4) == 0) push(1, $urandom);
      dst_want = ($urandom_range(0, 2) == 0);
      if (down > 0) begin
        down--;
        if (down == 0) channel_up = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        channel_up = 1'b0;
        down = $urandom_range(1, 4);
      end
      step();
    end
    channel_up = 1'b1; dst_want = 1'b0;
    n = 0;
    while ((fq0.size() != 0 || fq1.size() != 0 || busy || in_frame) && n < 3000) begin
      step(); n++;
    end
    check_eq("drain_fifo0", fq0.size(), 0);
    check_eq("drain_fifo1", fq1.size(), 0);
    check_eq("drain_ref0", ref0.size(), 0);
    check_eq("drain_ref1", ref1.size(), 0);
    check_eq("drain_idle", {31'd0, busy}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
